// File: rtl/lsq_mem_responder.sv
// Memory-side responder for the load/store queue: single-cycle RAM access on
// acceptance, then a fixed-depth response pipeline that freezes under backpressure.
module lsq_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        loadStore,
  input  logic        sizeIn,
  input  logic [31:0] addressIn,
  input  logic [31:0] swData,
  input  logic [31:0] pcIn,
  input  logic [5:0]  ROBNumIn,
  input  logic [5:0]  destRegIn,
  output logic        respValid,
  input  logic        respReady,
  output logic        respIsLoad,
  output logic [31:0] respData,
  output logic [31:0] respPc,
  output logic [5:0]  respROBNum,
  output logic [5:0]  respDestReg,
  output logic        respErr
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef struct packed {
    logic        is_load;
    logic        err;
    logic [31:0] data;
    logic [31:0] pc;
    logic [5:0]  rob;
    logic [5:0]  dest;
  } resp_t;

  logic [31:0]          mem [DEPTH_WORDS];
  logic [LATENCY:1]     vld_pipe, vld_shift;
  resp_t [LATENCY:1]    st_pipe, st_shift;
  resp_t                new_resp, st_in;
  logic                 stall, accept, misal;
  logic [AW-1:0]        idx;
  logic [4:0]           lane_sel;
  logic [31:0]          rd_word, wr_word;
  logic [7:0]           lane_byte;
  logic                 unused_addr;

  assign stall    = vld_pipe[LATENCY] && !respReady;
  assign reqReady = !stall;
  assign accept   = reqValid && reqReady;

  // Higher address bits alias onto the RAM (modulo addressing).
  assign idx         = addressIn[AW+1:2];
  assign unused_addr = ^addressIn[31:AW+2];
  assign lane_sel    = {addressIn[1:0], 3'b000};
  assign misal       = !sizeIn && (addressIn[1:0] != 2'b00);
  assign rd_word     = mem[idx];
  assign lane_byte   = rd_word[lane_sel +: 8];

  always_comb begin
    wr_word = swData;
    if (sizeIn) begin
      wr_word = rd_word;
      wr_word[lane_sel +: 8] = swData[7:0];
    end
  end

  always_comb begin
    new_resp         = '0;
    new_resp.is_load = loadStore;
    new_resp.err     = misal;
    new_resp.pc      = pcIn;
    new_resp.rob     = ROBNumIn;
    new_resp.dest    = destRegIn;
    if (loadStore && !misal)
      new_resp.data = sizeIn ? {{24{lane_byte[7]}}, lane_byte} : rd_word;
  end

  always_ff @(posedge clk) begin
    if (accept && !loadStore && !misal) mem[idx] <= wr_word;
  end

  // Bubbles carry zeroed fields so idle stages never show stale tags.
  assign st_in = accept ? new_resp : '0;

  if (LATENCY == 1) begin : g_one
    assign vld_shift = accept;
    assign st_shift  = st_in;
  end else begin : g_multi
    assign vld_shift = {vld_pipe[LATENCY-1:1], accept};
    assign st_shift  = {st_pipe[LATENCY-1:1], st_in};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
      st_pipe  <= '0;
    end else if (!stall) begin
      vld_pipe <= vld_shift;
      st_pipe  <= st_shift;
    end
  end

  assign respValid   = vld_pipe[LATENCY];
  assign respIsLoad  = st_pipe[LATENCY].is_load;
  assign respErr     = st_pipe[LATENCY].err;
  assign respData    = st_pipe[LATENCY].data;
  assign respPc      = st_pipe[LATENCY].pc;
  assign respROBNum  = st_pipe[LATENCY].rob;
  assign respDestReg = st_pipe[LATENCY].dest;
endmodule

// File: tb/tb_lsq_mem_responder.sv
// Scoreboard bench: the stimulus pushes hand-computed responses on acceptance,
// and a negedge monitor pops and compares each consumed response.
module tb_lsq_mem_responder;
  localparam int LATENCY = 2;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        reqValid = 1'b0, reqReady, loadStore = 1'b0, sizeIn = 1'b0;
  logic [31:0] addressIn = '0, swData = '0, pcIn = '0;
  logic [5:0]  ROBNumIn = '0, destRegIn = '0;
  logic        respValid, respReady = 1'b1, respIsLoad, respErr;
  logic [31:0] respData, respPc;
  logic [5:0]  respROBNum, respDestReg;

  lsq_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LATENCY)) dut (
    .clk(clk), .rstn(rstn), .reqValid(reqValid), .reqReady(reqReady),
    .loadStore(loadStore), .sizeIn(sizeIn), .addressIn(addressIn), .swData(swData),
    .pcIn(pcIn), .ROBNumIn(ROBNumIn), .destRegIn(destRegIn),
    .respValid(respValid), .respReady(respReady), .respIsLoad(respIsLoad),
    .respData(respData), .respPc(respPc), .respROBNum(respROBNum),
    .respDestReg(respDestReg), .respErr(respErr));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_load;
    bit          err;
    logic [31:0] data;
    logic [31:0] pc;
    logic [5:0]  rob;
    logic [5:0]  dest;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q[$];
  int checks = 0, passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passes++;
  endtask

  // Drive a request and hold it until accepted; record the expected completion.
  task automatic issue(input bit ld, input bit sz, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] pc, input logic [5:0] rob, input logic [5:0] dst,
                       input bit err, input logic [31:0] edata, input bit lat);
    exp_t e;
    bit ok = 1'b0;
    int c = 0;
    reqValid = 1'b1; loadStore = ld; sizeIn = sz; addressIn = a; swData = d;
    pcIn = pc; ROBNumIn = rob; destRegIn = dst;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = reqReady;
      c = cyc;
      @(posedge clk);
    end
    #1 reqValid = 1'b0;
    if (!ok) begin
      checks++;
      $display("FAIL accept_timeout: pc %0h never accepted", pc);
    end else begin
      e.is_load = ld; e.err = err; e.data = edata; e.pc = pc; e.rob = rob; e.dest = dst;
      e.acc = c + 1; e.lat = lat;
      q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && respValid && respReady) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_resp: got pc %0h expected none", respPc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pc", respPc, e.pc);
        chk("is_load", {31'd0, respIsLoad}, {31'd0, e.is_load});
        chk("err", {31'd0, respErr}, {31'd0, e.err});
        chk("data", respData, e.data);
        chk("rob", {26'd0, respROBNum}, {26'd0, e.rob});
        chk("dest", {26'd0, respDestReg}, {26'd0, e.dest});
        if (e.lat) chk("latency", cyc, e.acc + LATENCY - 1);
      end
    end
  end

  logic [31:0] held_pc;

  initial begin
    #3;
    chk("rst_valid", {31'd0, respValid}, 0);
    chk("rst_isload", {31'd0, respIsLoad}, 0);
    chk("rst_err", {31'd0, respErr}, 0);
    chk("rst_data", respData, 0);
    chk("rst_pc", respPc, 0);
    chk("rst_rob", {26'd0, respROBNum}, 0);
    chk("rst_dest", {26'd0, respDestReg}, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    chk("rst_ready", {31'd0, reqReady}, 1);

    // word store then dependent load, latency checked
    issue(0, 0, 32'h4, 32'h23, 32'h100, 6'd1, 6'd3, 0, 32'h0, 1);
    issue(1, 0, 32'h4, 32'h0, 32'h104, 6'd5, 6'd12, 0, 32'h23, 1);
    // byte store into a zeroed word, then word/byte loads
    issue(0, 0, 32'h8, 32'h0, 32'h108, 6'd6, 6'd0, 0, 32'h0, 0);
    issue(0, 1, 32'h9, 32'h80, 32'h10C, 6'd7, 6'd0, 0, 32'h0, 0);
    issue(1, 0, 32'h8, 32'h0, 32'h110, 6'd8, 6'd20, 0, 32'h0000_8000, 0);
    issue(1, 1, 32'h9, 32'h0, 32'h114, 6'd9, 6'd21, 0, 32'hFFFF_FF80, 0);
    issue(1, 1, 32'h8, 32'h0, 32'h118, 6'd10, 6'd22, 0, 32'h0, 0);
    // back-to-back store/load to the same word, consecutive responses
    issue(0, 0, 32'h8, 32'h46, 32'h11C, 6'd11, 6'd0, 0, 32'h0, 1);
    issue(1, 0, 32'h8, 32'h0, 32'h120, 6'd12, 6'd23, 0, 32'h46, 1);
    // address wrap (0x40C aliases word 3), then byte store using only swData[7:0]
    issue(0, 0, 32'h40C, 32'hCAFE_F00D, 32'h124, 6'd13, 6'd0, 0, 32'h0, 0);
    issue(0, 1, 32'hE, 32'hABCD_12F0, 32'h128, 6'd14, 6'd0, 0, 32'h0, 0);
    issue(1, 0, 32'hC, 32'h0, 32'h12C, 6'd15, 6'd24, 0, 32'hCAF0_F00D, 0);
    // misaligned word store / load
    issue(0, 0, 32'h6, 32'hFFFF, 32'h130, 6'd16, 6'd25, 1, 32'h0, 0);
    issue(1, 0, 32'h4, 32'h0, 32'h134, 6'd17, 6'd26, 0, 32'h23, 0);
    issue(1, 0, 32'h5, 32'h0, 32'h138, 6'd18, 6'd27, 1, 32'h0, 0);
    repeat (4) @(posedge clk);
    #1;

    // backpressure with three requests outstanding
    respReady = 1'b0;
    issue(1, 0, 32'h4, 32'h0, 32'h200, 6'd30, 6'd1, 0, 32'h23, 0);
    issue(1, 0, 32'h8, 32'h0, 32'h204, 6'd31, 6'd2, 0, 32'h46, 0);
    fork
      issue(1, 1, 32'h8, 32'h0, 32'h208, 6'd32, 6'd3, 0, 32'h46, 0);
      begin
        held_pc = 32'h200;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_ready", {31'd0, reqReady}, 0);
          chk("stall_valid", {31'd0, respValid}, 1);
          chk("stall_pc", respPc, held_pc);
        end
        @(posedge clk);
        #1 respReady = 1'b1;
      end
    join
    repeat (5) @(posedge clk);
    #1;

    // reset with two loads in flight
    issue(1, 0, 32'h4, 32'h0, 32'h300, 6'd40, 6'd4, 0, 32'h23, 0);
    issue(1, 0, 32'h8, 32'h0, 32'h304, 6'd41, 6'd5, 0, 32'h46, 0);
    chk("pre_rst_valid", {31'd0, respValid}, 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, respValid}, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    chk("post_rst_ready", {31'd0, reqReady}, 1);
    repeat (4) @(posedge clk);
    #1;
    issue(1, 0, 32'h4, 32'h0, 32'h308, 6'd42, 6'd6, 0, 32'h23, 1);
    issue(1, 0, 32'hC, 32'h0, 32'h30C, 6'd43, 6'd7, 0, 32'hCAF0_F00D, 1);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
